// File: rtl/reflet_vga_rect_fill_pkg.sv
// Shared VGA definitions: fill FSM state encoding and coordinate width/limit helpers.
package reflet_vga_rect_fill_pkg;

  // IDLE accepts commands, FILL streams one pixel per cycle.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_t;

  // Coordinate width after dropping the reduced low-order bits.
  function automatic int coord_w(input int size, input int reduction);
    return $clog2(size) - reduction;
  endfunction

  // Largest visible coordinate in reduced resolution.
  function automatic int coord_max(input int size, input int reduction);
    return (size >> reduction) - 1;
  endfunction

endpackage

// File: rtl/reflet_vga_rect_fill_norm.sv
// Combinational corner sort and screen clip for a rectangle command.
module reflet_vga_rect_fill_norm #(
  parameter int XW   = 10,
  parameter int YW   = 9,
  parameter int XMAX = 639,
  parameter int YMAX = 479
) (
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y0,
  input  logic [YW-1:0] y1,
  output logic [XW-1:0] xl,
  output logic [XW-1:0] xh,
  output logic [YW-1:0] yl,
  output logic [YW-1:0] yh,
  output logic          empty
);

  localparam logic [XW-1:0] XMAX_V = XW'(XMAX);
  localparam logic [YW-1:0] YMAX_V = YW'(YMAX);

  logic [XW-1:0] xh_raw_s;
  logic [YW-1:0] yh_raw_s;

  // Sort corners, clamp the far edges to the screen and flag rectangles fully off-screen.
  always_comb begin
    xl       = x0;
    xh_raw_s = x1;
    yl       = y0;
    yh_raw_s = y1;
    if (x1 < x0) begin
      xl       = x1;
      xh_raw_s = x0;
    end else begin
      xl       = x0;
      xh_raw_s = x1;
    end
    if (y1 < y0) begin
      yl       = y1;
      yh_raw_s = y0;
    end else begin
      yl       = y0;
      yh_raw_s = y1;
    end
    if (xh_raw_s > XMAX_V) begin
      xh = XMAX_V;
    end else begin
      xh = xh_raw_s;
    end
    if (yh_raw_s > YMAX_V) begin
      yh = YMAX_V;
    end else begin
      yh = yh_raw_s;
    end
    empty = (xl > XMAX_V) || (yl > YMAX_V);
  end

endmodule

// File: rtl/reflet_vga_rect_fill.sv
// Rectangle filler: accepts a corner pair and colour, then emits one pixel write per cycle in raster order.
module reflet_vga_rect_fill
  import reflet_vga_rect_fill_pkg::*;
#(
  parameter int h_size        = 640,
  parameter int v_line        = 480,
  parameter int color_depth   = 8,
  parameter int bit_reduction = 0,
  localparam int XW   = coord_w(h_size, bit_reduction),
  localparam int YW   = coord_w(v_line, bit_reduction),
  localparam int XMAX = coord_max(h_size, bit_reduction),
  localparam int YMAX = coord_max(v_line, bit_reduction)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [XW-1:0]          cmd_x0,
  input  logic [XW-1:0]          cmd_x1,
  input  logic [YW-1:0]          cmd_y0,
  input  logic [YW-1:0]          cmd_y1,
  input  logic [color_depth-1:0] cmd_R,
  input  logic [color_depth-1:0] cmd_G,
  input  logic [color_depth-1:0] cmd_B,
  input  logic [color_depth-1:0] cmd_a,
  output logic                   write_en,
  output logic [XW-1:0]          h_pixel,
  output logic [YW-1:0]          v_pixel,
  output logic [color_depth-1:0] R_out,
  output logic [color_depth-1:0] G_out,
  output logic [color_depth-1:0] B_out,
  output logic [color_depth-1:0] a_out,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = 4 * color_depth;

  fill_state_t   state_r, state_n;
  logic          ready_r, ready_n;
  logic          write_en_r, write_en_n;
  logic          done_r, done_n;
  logic          busy_r, busy_n;
  logic [XW-1:0] h_r, h_n;
  logic [YW-1:0] v_r, v_n;
  logic [XW-1:0] xl_r, xl_n;
  logic [XW-1:0] xh_r, xh_n;
  logic [YW-1:0] yh_r, yh_n;
  logic [CW-1:0] colour_r, colour_n;

  logic [XW-1:0] nxl_s, nxh_s;
  logic [YW-1:0] nyl_s, nyh_s;
  logic          empty_s;

  reflet_vga_rect_fill_norm #(
    .XW   (XW),
    .YW   (YW),
    .XMAX (XMAX),
    .YMAX (YMAX)
  ) u_norm (
    .x0    (cmd_x0),
    .x1    (cmd_x1),
    .y0    (cmd_y0),
    .y1    (cmd_y1),
    .xl    (nxl_s),
    .xh    (nxh_s),
    .yl    (nyl_s),
    .yh    (nyh_s),
    .empty (empty_s)
  );

  // Next-state and next-output decode; the registers always hold the pixel being written.
  always_comb begin
    state_n    = state_r;
    write_en_n = 1'b0;
    done_n     = 1'b0;
    h_n        = h_r;
    v_n        = v_r;
    xl_n       = xl_r;
    xh_n       = xh_r;
    yh_n       = yh_r;
    colour_n   = colour_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && ready_r) begin
          if (empty_s) begin
            done_n = 1'b1;
          end else begin
            state_n    = ST_FILL;
            write_en_n = 1'b1;
            h_n        = nxl_s;
            v_n        = nyl_s;
            xl_n       = nxl_s;
            xh_n       = nxh_s;
            yh_n       = nyh_s;
            colour_n   = {cmd_R, cmd_G, cmd_B, cmd_a};
            done_n     = (nxl_s == nxh_s) && (nyl_s == nyh_s);
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_FILL: begin
        if ((h_r == xh_r) && (v_r == yh_r)) begin
          state_n = ST_IDLE;
        end else begin
          write_en_n = 1'b1;
          if (h_r == xh_r) begin
            h_n = xl_r;
            v_n = v_r + YW'(1);
          end else begin
            h_n = h_r + XW'(1);
          end
          done_n = (h_n == xh_r) && (v_n == yh_r);
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    busy_n  = (state_n == ST_FILL);
    ready_n = (state_n == ST_IDLE);
  end

  // State and output registers with synchronous active-low reset; reset aborts any fill.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      ready_r    <= 1'b0;
      write_en_r <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      h_r        <= '0;
      v_r        <= '0;
      xl_r       <= '0;
      xh_r       <= '0;
      yh_r       <= '0;
      colour_r   <= '0;
    end else begin
      state_r    <= state_n;
      ready_r    <= ready_n;
      write_en_r <= write_en_n;
      done_r     <= done_n;
      busy_r     <= busy_n;
      h_r        <= h_n;
      v_r        <= v_n;
      xl_r       <= xl_n;
      xh_r       <= xh_n;
      yh_r       <= yh_n;
      colour_r   <= colour_n;
    end
  end

  assign cmd_ready = ready_r;
  assign write_en  = write_en_r;
  assign done      = done_r;
  assign busy      = busy_r;
  assign h_pixel   = h_r;
  assign v_pixel   = v_r;
  assign R_out     = colour_r[CW-1 -: color_depth];
  assign G_out     = colour_r[CW-1-color_depth -: color_depth];
  assign B_out     = colour_r[CW-1-2*color_depth -: color_depth];
  assign a_out     = colour_r[color_depth-1:0];

endmodule

// File: tb/tb_reflet_vga_rect_fill.sv
// Randomized self-checking bench for reflet_vga_rect_fill at 640x480, 8-bit colour.
module tb_reflet_vga_rect_fill;

  localparam int XW   = 10;
  localparam int YW   = 9;
  localparam int XMAX = 639;
  localparam int YMAX = 479;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [XW-1:0] cmd_x0, cmd_x1;
  logic [YW-1:0] cmd_y0, cmd_y1;
  logic [7:0]    cmd_R, cmd_G, cmd_B, cmd_a;
  logic          write_en;
  logic [XW-1:0] h_pixel;
  logic [YW-1:0] v_pixel;
  logic [7:0]    R_out, G_out, B_out, a_out;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  reflet_vga_rect_fill dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x0    (cmd_x0),
    .cmd_x1    (cmd_x1),
    .cmd_y0    (cmd_y0),
    .cmd_y1    (cmd_y1),
    .cmd_R     (cmd_R),
    .cmd_G     (cmd_G),
    .cmd_B     (cmd_B),
    .cmd_a     (cmd_a),
    .write_en  (write_en),
    .h_pixel   (h_pixel),
    .v_pixel   (v_pixel),
    .R_out     (R_out),
    .G_out     (G_out),
    .B_out     (B_out),
    .a_out     (a_out),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int x0, input int x1, input int y0, input int y1, input logic [31:0] col);
    logic [31:0] xa, xb, ya, yb;
    xa = x0; xb = x1; ya = y0; yb = y1;
    cmd_x0 = xa[XW-1:0];
    cmd_x1 = xb[XW-1:0];
    cmd_y0 = ya[YW-1:0];
    cmd_y1 = yb[YW-1:0];
    {cmd_R, cmd_G, cmd_B, cmd_a} = col;
    cmd_valid = 1'b1;
  endtask

  // Reference: called at the negedge right after the accepting edge. Checks the whole
  // write sequence from the rectangle's arithmetic, stopping early after 'limit' writes if limit>=0.
  task automatic expect_fill(input int x0, input int x1, input int y0, input int y1,
                             input logic [31:0] col, input int limit);
    int xl, xh, yl, yh, w, n, stop;
    xl = (x0 < x1) ? x0 : x1;
    xh = (x0 < x1) ? x1 : x0;
    yl = (y0 < y1) ? y0 : y1;
    yh = (y0 < y1) ? y1 : y0;
    if (xh > XMAX) xh = XMAX;
    if (yh > YMAX) yh = YMAX;
    if (xl > XMAX || yl > YMAX) begin
      check_eq("empty_we", 32'(write_en), 32'd0);
      check_eq("empty_done", 32'(done), 32'd1);
      check_eq("empty_busy", 32'(busy), 32'd0);
      check_eq("empty_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      check_eq("empty_done_end", 32'(done), 32'd0);
      check_eq("empty_we_end", 32'(write_en), 32'd0);
    end else begin
      w = xh - xl + 1;
      n = w * (yh - yl + 1);
      stop = (limit >= 0 && limit < n) ? limit : n;
      for (int i = 0; i < stop; i++) begin
        check_eq("we", 32'(write_en), 32'd1);
        check_eq("h_pixel", 32'(h_pixel), 32'(xl + (i % w)));
        check_eq("v_pixel", 32'(v_pixel), 32'(yl + (i / w)));
        check_eq("colour", {R_out, G_out, B_out, a_out}, col);
        check_eq("done", 32'(done), 32'(i == n - 1));
        check_eq("busy", 32'(busy), 32'd1);
        check_eq("ready_fill", 32'(cmd_ready), 32'd0);
        if (i < stop - 1 || stop == n) @(negedge clk);
      end
      if (stop == n) begin
        check_eq("idle_we", 32'(write_en), 32'd0);
        check_eq("idle_done", 32'(done), 32'd0);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_ready", 32'(cmd_ready), 32'd1);
      end
    end
  endtask

  // Issue one command from an idle negedge and check its full response.
  task automatic run_cmd(input int x0, input int x1, input int y0, input int y1, input logic [31:0] col);
    drive(x0, x1, y0, y1, col);
    check_eq("ready_at_issue", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    expect_fill(x0, x1, y0, y1, col, -1);
  endtask

  function automatic int pick_far(input int base, input int d, input int maxv);
    return (base + d > maxv) ? base - d : base + d;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_we"}, 32'(write_en), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_ready"}, 32'(cmd_ready), 32'd0);
    check_eq({tag, "_h"}, 32'(h_pixel), 32'd0);
    check_eq({tag, "_v"}, 32'(v_pixel), 32'd0);
    check_eq({tag, "_colour"}, {R_out, G_out, B_out, a_out}, 32'd0);
  endtask

  initial begin
    int x0, x1, y0, y1;
    logic [31:0] col;
    reset = 1'b0;
    cmd_valid = 1'b0;
    cmd_x0 = '0; cmd_x1 = '0; cmd_y0 = '0; cmd_y1 = '0;
    cmd_R = 8'd0; cmd_G = 8'd0; cmd_B = 8'd0; cmd_a = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
    check_eq("ready_after_release", 32'(cmd_ready), 32'd1);
    check_eq("busy_after_release", 32'(busy), 32'd0);

    run_cmd(2, 4, 3, 5, 32'h11223344);
    run_cmd(10, 7, 1, 0, 32'hA5B6C7D8);
    run_cmd(630, 700, 470, 500, 32'h0F1E2D3C);
    run_cmd(650, 660, 0, 5, 32'hDEADBEEF);
    run_cmd(5, 5, 9, 9, 32'h01020304);
    run_cmd(639, 639, 479, 479, 32'hFFFFFFFF);

    // Back-to-back: second command held valid throughout the first fill.
    drive(20, 23, 30, 31, 32'hAAAAAAAA);
    check_eq("b2b_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    drive(41, 40, 12, 10, 32'h55555555);
    expect_fill(20, 23, 30, 31, 32'hAAAAAAAA, -1);
    @(negedge clk);
    cmd_valid = 1'b0;
    expect_fill(41, 40, 12, 10, 32'h55555555, -1);
    @(negedge clk);

    // Reset during a fill after 50 writes.
    drive(0, 99, 0, 99, 32'h12345678);
    @(negedge clk);
    cmd_valid = 1'b0;
    expect_fill(0, 99, 0, 99, 32'h12345678, 50);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    @(negedge clk);
    check_reset_outputs("abort_hold");
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_ready", 32'(cmd_ready), 32'd1);
    check_eq("abort_we", 32'(write_en), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);

    // Randomized small rectangles, some near or past the screen edges.
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        x0 = $urandom_range(600, 700);
        y0 = $urandom_range(440, 511);
      end else begin
        x0 = $urandom_range(0, 1023);
        y0 = $urandom_range(0, 511);
      end
      x1 = pick_far(x0, $urandom_range(0, 15), 1023);
      y1 = pick_far(y0, $urandom_range(0, 12), 511);
      col = $urandom;
      run_cmd(x0, x1, y0, y1, col);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
